demux2_stream: RTL and testbench
================================

DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 Parameter: n, 32, data width in bits of the input and of each output.
REQ-002 Port: CLOCK  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: RESET  input  1  synchronous, active-high reset.
REQ-004 Port: S  input  1  route select (0 -> output 0, 1 -> output 1), sampled with D.
REQ-005 Port: D  input  n  input data word.
REQ-006 Port: VALID_IN  input  1  D and S valid this cycle.
REQ-007 Port: READY_IN  output  1  block accepts the word this cycle.
REQ-008 Port: Y0, Y1  output  n  head word of buffer 0 and buffer 1.
REQ-009 Port: VALID0, VALID1  output  1  Y0 or Y1 holds a valid word.
REQ-010 Port: READY0, READY1  input  1  downstream consumer of Y0 or Y1 takes the word this cycle.
REQ-011 Port (DEMUX2_STATS_EN only): COUNT0, COUNT1  output  16  words accepted for output 0 and output 1.

Function
REQ-012 Block SHALL contain one 2-entry buffer per output.
REQ-013 Each buffer SHALL have states EMPTY, ONE and FULL.
REQ-014 READY_IN SHALL equal NOT(buffer[S] is FULL).
REQ-015 READY_IN SHALL have no combinational path from READY0 or READY1.
REQ-016 Accept occurs when VALID_IN & READY_IN; the word is written to buffer[S] at that edge.
REQ-017 Latency SHALL be 1 cycle: a word accepted into an EMPTY buffer is presented on Yk with VALIDk=1 the next cycle.
REQ-018 Pop occurs when VALIDk & READYk; the head entry is removed at that edge.
REQ-019 Buffer transitions SHALL be:
- push only: EMPTY->ONE, ONE->FULL.
- pop only: ONE->EMPTY, FULL->ONE.
- push and pop together in ONE: stays ONE, with the new word becoming head.
REQ-020 Push into FULL SHALL never occur.
REQ-021 Each output SHALL preserve FIFO order.
REQ-022 Buffers SHALL not block each other: a FULL buffer 1 does not stall words routed to output 0.
REQ-023 VALIDk SHALL equal NOT(buffer k is EMPTY).
REQ-024 Yk SHALL be 0 while buffer k is EMPTY.
REQ-025 VALID_IN=0 SHALL leave state unchanged apart from pops; S and D are don't-care.

Reset
REQ-026 On a RESET edge, both buffers SHALL go to EMPTY; VALID0=VALID1=0; Y0=Y1=0; COUNT0=COUNT1=0.
REQ-027 RESET SHALL override a simultaneous push or pop; buffered words are discarded.
REQ-028 READY_IN SHALL be 1 in the first cycle after RESET deasserts.

Configuration
REQ-029 Macro DEMUX2_STATS_EN defined: COUNT0 and COUNT1 exist; each increments by 1 on every accept to its output and saturates at 16'hFFFF.
REQ-030 Macro DEMUX2_STATS_EN undefined: COUNT ports and counter logic are absent; all other behaviour is identical.

Structure
REQ-031 Package demux2_pkg SHALL hold enum buf_state_t {EMPTY, ONE, FULL} and constant COUNT_W = 16.
REQ-032 Sub-module fifo2 SHALL implement one 2-entry buffer (parameter n; push, pop, data in/out, empty, full) and be instantiated twice.
REQ-033 Top level SHALL contain only the route/handshake logic and the optional counters.

Verification
REQ-034 Reset then single word: after RESET, VALID_IN=1, S=0, D=32'h80000000 for one cycle with READY0=1 -> next cycle VALID0=1, Y0=32'h80000000; following cycle VALID0=0, Y0=0; VALID1 stays 0.
REQ-035 Route to output 1 with backpressure: READY1=0; push 32'h00000001 then 32'h00000002 with S=1 -> READY_IN=0 for S=1 after the second push, while a S=0 word 32'hA5A5A5A5 is still accepted.
REQ-036 Drain order: READY1 raised after REQ-035 -> Y1 = 32'h00000001, then 32'h00000002, then VALID1=0.
REQ-037 Simultaneous push/pop in ONE: buffer 0 holds 32'h11, READY0=1, push 32'h22 with S=0 in the same cycle -> next cycle Y0=32'h22, VALID0=1, state ONE.
REQ-038 Reset mid-operation: both buffers FULL, then RESET asserted with VALID_IN=1 -> next cycle VALID0=VALID1=0, Y0=Y1=0, READY_IN=1; the word presented during RESET is lost.
REQ-039 Stats (DEMUX2_STATS_EN): after 3 accepts to output 0 and 2 to output 1 -> COUNT0=3, COUNT1=2; with COUNT0 forced to 16'hFFFF, one more accept -> COUNT0 stays 16'hFFFF.

Source files
------------

// File: rtl/demux2_pkg.sv
// Shared types and constants for the two-output stream demultiplexer.
// Optional statistics counters are enabled with the DEMUX2_STATS_EN macro.
package demux2_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } buf_state_t;

  localparam int COUNT_W = 16;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux2_stream_fifo2.sv
// fifo2: two-entry FIFO with EMPTY/ONE/FULL occupancy tracking.
// Head word is presented on dout, forced to zero while the buffer is empty.
module fifo2
  import demux2_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [n-1:0] din,
  output logic [n-1:0] dout,
  output logic         empty,
  output logic         full
);

  buf_state_t   state;
  logic [n-1:0] head;
  logic [n-1:0] tail;

  // Occupancy FSM and storage; push into FULL and pop from EMPTY are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head  <= din;
            state <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b10: begin
              tail  <= din;
              state <= FULL;
            end
            2'b01: state <= EMPTY;
            // Old head leaves while the new word arrives: new word is head.
            2'b11: head <= din;
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Status and masked head word derived from the registered state.
  always_comb begin
    empty = (state == EMPTY);
    full  = (state == FULL);
    dout  = empty ? '0 : head;
  end

endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: routes an input stream to one of two buffered outputs by S.
// Each output has its own two-entry buffer so one stalled output never blocks
// the other. Macro DEMUX2_STATS_EN adds saturating per-output accept counters
// on ports COUNT0/COUNT1.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int n = 32
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               S,
  input  logic [n-1:0]       D,
  input  logic               VALID_IN,
  output logic               READY_IN,
  output logic [n-1:0]       Y0,
  output logic [n-1:0]       Y1,
  output logic               VALID0,
  output logic               VALID1,
  input  logic               READY0,
  input  logic               READY1
`ifdef DEMUX2_STATS_EN
  ,
  output logic [COUNT_W-1:0] COUNT0,
  output logic [COUNT_W-1:0] COUNT1
`endif
);

  logic empty0, empty1;
  logic full0, full1;
  logic accept;
  logic push0, push1;
  logic pop0, pop1;

  // Route/handshake: ready depends only on the selected buffer's registered
  // fullness, so there is no path from READY0/READY1 to READY_IN.
  always_comb begin
    READY_IN = S ? ~full1 : ~full0;
    accept   = VALID_IN & READY_IN;
    push0    = accept & ~S;
    push1    = accept & S;
    VALID0   = ~empty0;
    VALID1   = ~empty1;
    pop0     = VALID0 & READY0;
    pop1     = VALID1 & READY1;
  end

  fifo2 #(
    .n(n)
  ) u_buf0 (
    .clk  (CLOCK),
    .rst  (RESET),
    .push (push0),
    .pop  (pop0),
    .din  (D),
    .dout (Y0),
    .empty(empty0),
    .full (full0)
  );

  fifo2 #(
    .n(n)
  ) u_buf1 (
    .clk  (CLOCK),
    .rst  (RESET),
    .push (push1),
    .pop  (pop1),
    .din  (D),
    .dout (Y1),
    .empty(empty1),
    .full (full1)
  );

`ifdef DEMUX2_STATS_EN
  logic [COUNT_W-1:0] cnt0;
  logic [COUNT_W-1:0] cnt1;

  // Saturating count of words accepted for each output.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) cnt0 <= sat_inc(cnt0);
      if (push1) cnt1 <= sat_inc(cnt1);
    end
  end

  assign COUNT0 = cnt0;
  assign COUNT1 = cnt1;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Testbench for demux2_stream: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_demux2_stream;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        S = 1'b0;
  logic [31:0] D = '0;
  logic        VALID_IN = 1'b0;
  logic        READY_IN;
  logic [31:0] Y0, Y1;
  logic        VALID0, VALID1;
  logic        READY0 = 1'b0;
  logic        READY1 = 1'b0;
`ifdef DEMUX2_STATS_EN
  logic [15:0] COUNT0, COUNT1;
  logic [15:0] m_c0 = '0;
  logic [15:0] m_c1 = '0;
`endif

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  demux2_stream #(.n(32)) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .S       (S),
    .D       (D),
    .VALID_IN(VALID_IN),
    .READY_IN(READY_IN),
    .Y0      (Y0),
    .Y1      (Y1),
    .VALID0  (VALID0),
    .VALID1  (VALID1),
    .READY0  (READY0),
    .READY1  (READY1)
`ifdef DEMUX2_STATS_EN
    ,
    .COUNT0  (COUNT0),
    .COUNT1  (COUNT1)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each output is a FIFO of at most two words; pops of the
  // head happen before the accepted word is appended.
  always @(posedge CLOCK) begin
    bit p0, p1, acc;
    if (RESET) begin
      q0.delete();
      q1.delete();
`ifdef DEMUX2_STATS_EN
      m_c0 = '0;
      m_c1 = '0;
`endif
      chk_en = 1'b1;
    end else begin
      p0  = (q0.size() != 0) && (READY0 === 1'b1);
      p1  = (q1.size() != 0) && (READY1 === 1'b1);
      acc = (VALID_IN === 1'b1) && (S ? (q1.size() < 2) : (q0.size() < 2));
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (S) begin
          q1.push_back(D);
`ifdef DEMUX2_STATS_EN
          if (m_c1 != 16'hFFFF) m_c1 = m_c1 + 16'd1;
`endif
        end else begin
          q0.push_back(D);
`ifdef DEMUX2_STATS_EN
          if (m_c0 != 16'hFFFF) m_c0 = m_c0 + 16'd1;
`endif
        end
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge CLOCK) begin
    if (chk_en) begin
      chk("m_valid0", {31'd0, VALID0}, {31'd0, q0.size() != 0});
      chk("m_valid1", {31'd0, VALID1}, {31'd0, q1.size() != 0});
      chk("m_y0", Y0, (q0.size() != 0) ? q0[0] : 32'd0);
      chk("m_y1", Y1, (q1.size() != 0) ? q1[0] : 32'd0);
      chk("m_ready_in", {31'd0, READY_IN},
          {31'd0, S ? (q1.size() < 2) : (q0.size() < 2)});
`ifdef DEMUX2_STATS_EN
      chk("m_count0", {16'd0, COUNT0}, {16'd0, m_c0});
      chk("m_count1", {16'd0, COUNT1}, {16'd0, m_c1});
`endif
    end
  end

  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLOCK);
  endtask

  initial begin
    // Reset
    cyc();
    cyc();
    RESET = 1'b0;
    at_neg();
    chk("rst_ready_in", {31'd0, READY_IN}, 32'd1);
    chk("rst_valid0", {31'd0, VALID0}, 32'd0);
    chk("rst_y1", Y1, 32'd0);

    // Single word through output 0
    READY0 = 1'b1; VALID_IN = 1'b1; S = 1'b0; D = 32'h80000000;
    cyc();
    VALID_IN = 1'b0;
    at_neg();
    chk("single_valid0", {31'd0, VALID0}, 32'd1);
    chk("single_y0", Y0, 32'h80000000);
    chk("single_valid1", {31'd0, VALID1}, 32'd0);
    cyc();
    at_neg();
    chk("single_valid0_after", {31'd0, VALID0}, 32'd0);
    chk("single_y0_after", Y0, 32'd0);

    // Backpressure on output 1 must not block output 0
    READY0 = 1'b0; READY1 = 1'b0; VALID_IN = 1'b1; S = 1'b1; D = 32'h00000001;
    cyc();
    D = 32'h00000002;
    cyc();
    D = 32'h00000003;
    at_neg();
    chk("bp_ready_in_s1", {31'd0, READY_IN}, 32'd0);
    cyc();
    S = 1'b0; D = 32'hA5A5A5A5;
    at_neg();
    chk("bp_ready_in_s0", {31'd0, READY_IN}, 32'd1);
    cyc();
    VALID_IN = 1'b0; READY1 = 1'b1;
    at_neg();
    chk("bp_y0", Y0, 32'hA5A5A5A5);
    chk("drain_y1_first", Y1, 32'h00000001);
    cyc();
    at_neg();
    chk("drain_y1_second", Y1, 32'h00000002);
    cyc();
    at_neg();
    chk("drain_valid1_end", {31'd0, VALID1}, 32'd0);
    READY1 = 1'b0; READY0 = 1'b1;
    cyc();
    READY0 = 1'b0;
    at_neg();
    chk("drain_valid0_end", {31'd0, VALID0}, 32'd0);

    // Simultaneous push and pop while holding one word
    VALID_IN = 1'b1; S = 1'b0; D = 32'h11;
    cyc();
    READY0 = 1'b1; D = 32'h22;
    at_neg();
    chk("pp_y0_before", Y0, 32'h11);
    cyc();
    VALID_IN = 1'b0; READY0 = 1'b0;
    at_neg();
    chk("pp_y0_after", Y0, 32'h22);
    chk("pp_valid0", {31'd0, VALID0}, 32'd1);
    chk("pp_not_full", {31'd0, READY_IN}, 32'd1);
    READY0 = 1'b1;
    cyc();
    READY0 = 1'b0;

    // Reset with both buffers full and a word presented
    VALID_IN = 1'b1; S = 1'b0; D = 32'h0000000A;
    cyc();
    D = 32'h0000000B;
    cyc();
    S = 1'b1; D = 32'h0000000C;
    cyc();
    D = 32'h0000000D;
    cyc();
    RESET = 1'b1; S = 1'b0; D = 32'h0000000E; READY0 = 1'b1; READY1 = 1'b1;
    at_neg();
    chk("mid_full_ready_in", {31'd0, READY_IN}, 32'd0);
    chk("mid_full_y1", Y1, 32'h0000000C);
    cyc();
    RESET = 1'b0; VALID_IN = 1'b0; READY0 = 1'b0; READY1 = 1'b0;
    at_neg();
    chk("mid_rst_valid0", {31'd0, VALID0}, 32'd0);
    chk("mid_rst_valid1", {31'd0, VALID1}, 32'd0);
    chk("mid_rst_y0", Y0, 32'd0);
    chk("mid_rst_y1", Y1, 32'd0);
    chk("mid_rst_ready_in", {31'd0, READY_IN}, 32'd1);

`ifdef DEMUX2_STATS_EN
    // Statistics counters and saturation
    READY0 = 1'b1; READY1 = 1'b1; VALID_IN = 1'b1; S = 1'b0;
    for (int i = 0; i < 3; i++) begin
      D = 32'h100 + 32'(i);
      cyc();
    end
    S = 1'b1;
    for (int i = 0; i < 2; i++) begin
      D = 32'h200 + 32'(i);
      cyc();
    end
    VALID_IN = 1'b0;
    at_neg();
    chk("stat_count0", {16'd0, COUNT0}, 32'd3);
    chk("stat_count1", {16'd0, COUNT1}, 32'd2);
    cyc();
    force dut.cnt0 = 16'hFFFF;
    m_c0 = 16'hFFFF;
    #1;
    release dut.cnt0;
    VALID_IN = 1'b1; S = 1'b0; D = 32'h300;
    cyc();
    VALID_IN = 1'b0;
    at_neg();
    chk("stat_sat_count0", {16'd0, COUNT0}, 32'h0000FFFF);
    cyc();
`endif

    // Mixed traffic with varied backpressure, checked by the model
    for (int i = 0; i < 80; i++) begin
      VALID_IN = (i % 4) != 3;
      S        = ((i / 3) % 2) == 1;
      D        = 32'h10000000 + 32'(i);
      READY0   = (i % 5) > 1;
      READY1   = (i % 3) == 0;
      cyc();
    end
    VALID_IN = 1'b0; READY0 = 1'b1; READY1 = 1'b1;
    cyc();
    cyc();
    cyc();
    at_neg();
    chk("final_valid0", {31'd0, VALID0}, 32'd0);
    chk("final_valid1", {31'd0, VALID1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
